// File: rtl/mcu_control_pkg.sv
// Shared definitions for the 12-bit microcontroller control path and datapath:
// opcode map, ALU op codes, FSM state encoding and the decoded-instruction bundle.
package mcu_control_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 8;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LDI  = 4'h1;
  localparam opcode_t OP_LDM  = 4'h2;
  localparam opcode_t OP_STM  = 4'h3;
  localparam opcode_t OP_ADD  = 4'h4;
  localparam opcode_t OP_ADDI = 4'h5;
  localparam opcode_t OP_SUB  = 4'h6;
  localparam opcode_t OP_SUBI = 4'h7;
  localparam opcode_t OP_AND  = 4'h8;
  localparam opcode_t OP_ANDI = 4'h9;
  localparam opcode_t OP_JMP  = 4'hA;
  localparam opcode_t OP_JZ   = 4'hB;
  localparam opcode_t OP_JC   = 4'hC;
  localparam opcode_t OP_RSVD_D = 4'hD;
  localparam opcode_t OP_RSVD_E = 4'hE;
  localparam opcode_t OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_ALWAYS = 2'd1,
    BR_ZERO   = 2'd2,
    BR_CARRY  = 2'd3
  } branch_t;

  typedef struct packed {
    logic    is_mem;
    logic    is_imm;
    logic    is_alu;
    logic    is_store;
    logic    is_branch;
    logic    is_halt;
    alu_op_t alu_op;
    branch_t br_cond;
  } decode_t;

  // Only arithmetic results carry meaningful carry/borrow; logic and loads clear C.
  function automatic logic alu_writes_carry(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/mcu_control_if.sv
// Control-path bundle between the mcu_control FSM (master) and the datapath (slave).
interface mcu_control_if #(
  parameter int OPW = 4,
  parameter int AW  = 8
);
  import mcu_control_pkg::*;

  logic          i_run;
  logic [OPW+AW-1:0] i_ir;
  logic          i_alu_zero;
  logic          i_alu_carry;

  logic          o_pc_en;
  logic          o_pc_sel;
  logic          o_ir_en;
  logic          o_dr_en;
  logic          o_alu_src;
  alu_op_t       o_alu_op;
  logic          o_acc_en;
  logic          o_ram_we;
  logic          o_halted;
  logic          o_retire;

  modport master (
    input  i_run, i_ir, i_alu_zero, i_alu_carry,
    output o_pc_en, o_pc_sel, o_ir_en, o_dr_en, o_alu_src, o_alu_op,
           o_acc_en, o_ram_we, o_halted, o_retire
  );

  modport slave (
    output i_run, i_ir, i_alu_zero, i_alu_carry,
    input  o_pc_en, o_pc_sel, o_ir_en, o_dr_en, o_alu_src, o_alu_op,
           o_acc_en, o_ram_we, o_halted, o_retire
  );

endinterface

// File: rtl/mcu_control_instr_decode.sv
// Pure combinational opcode classifier; reserved opcodes decode to an empty class (NOP).
module mcu_control_instr_decode
  import mcu_control_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output decode_t        dec
);

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_PASS;
    dec.br_cond = BR_NONE;
    case (opcode)
      OP_LDI:  begin dec.is_alu = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_PASS; end
      OP_LDM:  begin dec.is_alu = 1'b1; dec.is_mem = 1'b1; dec.alu_op = ALU_PASS; end
      OP_STM:  dec.is_store = 1'b1;
      OP_ADD:  begin dec.is_alu = 1'b1; dec.is_mem = 1'b1; dec.alu_op = ALU_ADD; end
      OP_ADDI: begin dec.is_alu = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB:  begin dec.is_alu = 1'b1; dec.is_mem = 1'b1; dec.alu_op = ALU_SUB; end
      OP_SUBI: begin dec.is_alu = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.is_alu = 1'b1; dec.is_mem = 1'b1; dec.alu_op = ALU_AND; end
      OP_ANDI: begin dec.is_alu = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_AND; end
      OP_JMP:  begin dec.is_branch = 1'b1; dec.br_cond = BR_ALWAYS; end
      OP_JZ:   begin dec.is_branch = 1'b1; dec.br_cond = BR_ZERO;   end
      OP_JC:   begin dec.is_branch = 1'b1; dec.br_cond = BR_CARRY;  end
      OP_HLT:  dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu_control.sv
// Instruction sequencer: FETCH -> DECODE -> [MEM] -> EXEC, plus HALT, with Z/C flags.
// Strobes are combinational from state and opcode and are all forced low during reset.
module mcu_control
  import mcu_control_pkg::*;
#(
  parameter int OPW = 4,
  parameter int AW  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mcu_control_if.master bus
);

  state_t   state_q, state_d;
  logic     z_q, z_d;
  logic     c_q, c_d;
  decode_t  dec;

  logic     pc_en, pc_sel, ir_en, dr_en, alu_src, acc_en, ram_we, halted, retire;
  alu_op_t  alu_op;
  logic     branch_taken;

  mcu_control_instr_decode #(.OPW(OPW)) u_decode (
    .opcode (bus.i_ir[OPW+AW-1 -: OPW]),
    .dec    (dec)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    case (dec.br_cond)
      BR_ALWAYS: branch_taken = 1'b1;
      BR_ZERO:   branch_taken = z_q;
      BR_CARRY:  branch_taken = c_q;
      default:   branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    c_d     = c_q;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    ir_en   = 1'b0;
    dr_en   = 1'b0;
    alu_src = 1'b0;
    alu_op  = ALU_PASS;
    acc_en  = 1'b0;
    ram_we  = 1'b0;
    halted  = 1'b0;
    retire  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (bus.i_run) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_halt)     state_d = ST_HALT;
        else if (dec.is_mem) state_d = ST_MEM;
        else                 state_d = ST_EXEC;
      end
      ST_MEM: begin
        dr_en   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (dec.is_alu) begin
          acc_en  = 1'b1;
          alu_src = dec.is_imm;
          alu_op  = dec.alu_op;
          z_d     = bus.i_alu_zero;
          c_d     = alu_writes_carry(dec.alu_op) ? bus.i_alu_carry : 1'b0;
        end
        if (dec.is_store)  ram_we = 1'b1;
        if (dec.is_branch) pc_sel = branch_taken;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Abandon any in-flight instruction: no strobe may escape while reset is low.
    if (!i_rst_n) begin
      pc_en   = 1'b0;
      pc_sel  = 1'b0;
      ir_en   = 1'b0;
      dr_en   = 1'b0;
      alu_src = 1'b0;
      alu_op  = ALU_PASS;
      acc_en  = 1'b0;
      ram_we  = 1'b0;
      halted  = 1'b0;
      retire  = 1'b0;
    end
  end

  assign bus.o_pc_en    = pc_en;
  assign bus.o_pc_sel   = pc_sel;
  assign bus.o_ir_en    = ir_en;
  assign bus.o_dr_en    = dr_en;
  assign bus.o_alu_src  = alu_src;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_acc_en   = acc_en;
  assign bus.o_ram_we   = ram_we;
  assign bus.o_halted   = halted;
  assign bus.o_retire   = retire;

endmodule
